// File: rtl/clk_div_mon_pkg.sv
// clk_div_mon_pkg
// Shared definitions for the divided-clock ratio monitor:
//   - mon_state_t : monitor FSM states (IDLE, WAIT_RISE, MEASURE)
//   - CNT_W_DEF / TIMEOUT_DEF : default counter width and stuck timeout
//   - abs_diff : unsigned absolute difference used by the duty check
package clk_div_mon_pkg;

    localparam int CNT_W_DEF   = 8;
    localparam int TIMEOUT_DEF = 512;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } mon_state_t;

    // Operands are zero-extended to 16 bits by the caller.
    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clk_div_ratio_monitor_edge.sv
// clk_edge_det
// Samples the divided clock and produces a one-cycle rise strobe.
// Optional macro CLK_DIV_MON_SYNC_EN inserts a 2-flop synchronizer in front
// of the sample so the input may be asynchronous to clk.
// Ports:
//   clk  : reference clock
//   rst  : synchronous active-high reset (all flops to 0)
//   d    : divided clock input
//   s    : sampled (optionally synchronized) divided clock level
//   rise : s & ~previous s
module clk_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic s,
    output logic rise
);

`ifdef CLK_DIV_MON_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b00;
        else     sync <= {sync[0], d};
    end

    assign s = sync[1];
`else
    assign s = d;
`endif

    // Previous sample is registered in every state so an edge right after
    // enable is judged against real history, not a reset value.
    logic p;

    always_ff @(posedge clk) begin
        if (rst) p <= 1'b0;
        else     p <= s;
    end

    assign rise = s & ~p;

endmodule

// File: rtl/clk_div_ratio_monitor.sv
// clk_div_ratio_monitor
// Measures a divided clock in reference-clock cycles once per divided period
// and flags ratio mismatch, duty imbalance and a stuck clock.
// Optional macro CLK_DIV_MON_SYNC_EN (in clk_edge_det) adds a 2-flop input
// synchronizer, delaying edge detection and o_valid by 2 cycles.
// Ports:
//   I_ref_clk   : reference clock, the only clock
//   I_rst       : synchronous active-high reset
//   I_en        : monitor enable
//   I_div_clk   : divided clock under test
//   I_exp_ratio : expected divide ratio (sampled in the rise cycle)
//   o_period    : last measured period (high + low)
//   o_high      : last measured high time
//   o_low       : last measured low time
//   o_valid     : one-cycle pulse when a measurement is loaded
//   o_ratio_err : period != expected ratio (qualified by o_valid)
//   o_duty_err  : |high - low| > 1 (qualified by o_valid)
//   o_stuck     : no rising edge within TIMEOUT cycles
module clk_div_ratio_monitor
    import clk_div_mon_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             I_ref_clk,
    input  logic             I_rst,
    input  logic             I_en,
    input  logic             I_div_clk,
    input  logic [CNT_W-1:0] I_exp_ratio,
    output logic [CNT_W:0]   o_period,
    output logic [CNT_W-1:0] o_high,
    output logic [CNT_W-1:0] o_low,
    output logic             o_valid,
    output logic             o_ratio_err,
    output logic             o_duty_err,
    output logic             o_stuck
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    mon_state_t        state;
    logic [CNT_W-1:0]  hi_cnt, lo_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              s, rise;

    clk_edge_det u_edge (
        .clk  (I_ref_clk),
        .rst  (I_rst),
        .d    (I_div_clk),
        .s    (s),
        .rise (rise)
    );

    logic [CNT_W:0] period_next;
    logic           ratio_bad, duty_bad;

    assign period_next = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    // Ratios 0/1 mean pass-through, which cannot be seen at ref rate.
    assign ratio_bad   = (I_exp_ratio > CNT_W'(1)) && (period_next != {1'b0, I_exp_ratio});
    assign duty_bad    = abs_diff(16'(hi_cnt), 16'(lo_cnt)) > 16'd1;

    always_ff @(posedge I_ref_clk) begin
        if (I_rst) begin
            state       <= IDLE;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            idle_cnt    <= '0;
            o_period    <= '0;
            o_high      <= '0;
            o_low       <= '0;
            o_valid     <= 1'b0;
            o_ratio_err <= 1'b0;
            o_duty_err  <= 1'b0;
            o_stuck     <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (!I_en) begin
                // Disable wins over a coincident rise; outputs keep last values.
                state    <= IDLE;
                hi_cnt   <= '0;
                lo_cnt   <= '0;
                idle_cnt <= '0;
                o_stuck  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        hi_cnt   <= '0;
                        lo_cnt   <= '0;
                        idle_cnt <= '0;
                        state    <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            // Period before this edge is incomplete: arm only.
                            hi_cnt   <= CNT_W'(1);
                            lo_cnt   <= '0;
                            idle_cnt <= '0;
                            o_stuck  <= 1'b0;
                            state    <= MEASURE;
                        end else if (!o_stuck) begin
                            if (idle_cnt == IDLE_LAST) o_stuck <= 1'b1;
                            else                       idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            o_period    <= period_next;
                            o_high      <= hi_cnt;
                            o_low       <= lo_cnt;
                            o_ratio_err <= ratio_bad;
                            o_duty_err  <= duty_bad;
                            o_valid     <= 1'b1;
                            hi_cnt      <= CNT_W'(1);
                            lo_cnt      <= '0;
                            idle_cnt    <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            o_stuck  <= 1'b1;
                            hi_cnt   <= '0;
                            lo_cnt   <= '0;
                            state    <= WAIT_RISE;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                            if (s) begin
                                if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + CNT_W'(1);
                            end else begin
                                if (lo_cnt != CNT_MAX) lo_cnt <= lo_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_ratio_monitor.sv
module tb_clk_div_ratio_monitor;

    localparam int TO = 512;
`ifdef CLK_DIV_MON_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       I_ref_clk = 1'b0;
    logic       I_rst = 1'b1;
    logic       I_en = 1'b0;
    logic       I_div_clk = 1'b0;
    logic [7:0] I_exp_ratio = 8'd0;
    logic [8:0] o_period;
    logic [7:0] o_high, o_low;
    logic       o_valid, o_ratio_err, o_duty_err, o_stuck;

    clk_div_ratio_monitor #(.CNT_W(8), .TIMEOUT(TO)) dut (
        .I_ref_clk   (I_ref_clk),
        .I_rst       (I_rst),
        .I_en        (I_en),
        .I_div_clk   (I_div_clk),
        .I_exp_ratio (I_exp_ratio),
        .o_period    (o_period),
        .o_high      (o_high),
        .o_low       (o_low),
        .o_valid     (o_valid),
        .o_ratio_err (o_ratio_err),
        .o_duty_err  (o_duty_err),
        .o_stuck     (o_stuck)
    );

    always #5 I_ref_clk = ~I_ref_clk;

    typedef struct packed {
        logic [8:0] period;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       rerr;
        logic       derr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   armed = 1'b0;
    int   prev_h = 0;
    int   prev_l = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // Scoreboard consumer: every o_valid pulse must match the oldest expectation.
    always @(negedge I_ref_clk) begin
        exp_t e;
        if (!I_rst && o_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_valid: observed o_valid=1 expected 0");
            end else begin
                e = q.pop_front();
                chk("period",    32'(o_period),    32'(e.period));
                chk("high",      32'(o_high),      32'(e.hi));
                chk("low",       32'(o_low),       32'(e.lo));
                chk("ratio_err", 32'(o_ratio_err), 32'(e.rerr));
                chk("duty_err",  32'(o_duty_err),  32'(e.derr));
            end
        end
    end

    task automatic cyc(input logic d);
        I_div_clk = d;
        @(posedge I_ref_clk);
        #1;
    endtask

    // One divided period of h high / l low cycles. Its first cycle is the rise
    // that closes the previous period, so that measurement is expected now.
    task automatic period(input int h, input int l, input int e);
        exp_t x;
        I_exp_ratio = 8'(e);
        if (armed) begin
            x.period = 9'(prev_h + prev_l);
            x.hi     = 8'(prev_h);
            x.lo     = 8'(prev_l);
            x.rerr   = (e > 1) && ((prev_h + prev_l) != e);
            x.derr   = ((prev_h > prev_l) ? (prev_h - prev_l) : (prev_l - prev_h)) > 1;
            q.push_back(x);
        end
        for (int i = 0; i < h; i++) cyc(1'b1);
        for (int i = 0; i < l; i++) cyc(1'b0);
        prev_h = h;
        prev_l = l;
        armed  = 1'b1;
    endtask

    initial begin
        // Reset with the divided clock toggling
        I_rst = 1'b1;
        cyc(1'b1); cyc(1'b0); cyc(1'b1);
        chk("rst_period", 32'(o_period),    32'd0);
        chk("rst_high",   32'(o_high),      32'd0);
        chk("rst_low",    32'(o_low),       32'd0);
        chk("rst_valid",  32'(o_valid),     32'd0);
        chk("rst_rerr",   32'(o_ratio_err), 32'd0);
        chk("rst_derr",   32'(o_duty_err),  32'd0);
        chk("rst_stuck",  32'(o_stuck),     32'd0);
        I_rst = 1'b0;
        I_en  = 1'b1;
        cyc(1'b0);

        // Divide-by-4, then divide-by-3 with a ratio change, then skewed
        repeat (4) period(2, 2, 4);
        repeat (3) period(1, 2, 3);
        repeat (2) period(1, 2, 5);
        repeat (3) period(1, 5, 6);
        repeat (2) period(1, 5, 0);
        repeat (2) period(2, 2, 4);

        // Stuck low: o_stuck exactly TO cycles after the last rise
        period(1, 0, 4);
        armed = 1'b0;
        for (int i = 0; i < TO - 1 + LAT; i++) cyc(1'b0);
        chk("stuck_before", 32'(o_stuck), 32'd0);
        cyc(1'b0);
        chk("stuck_at_timeout", 32'(o_stuck), 32'd1);
        cyc(1'b0);
        chk("stuck_held", 32'(o_stuck), 32'd1);

        // Resume: clears one cycle after the first detected rise, no measurement yet
        for (int i = 0; i < 4; i++) begin
            cyc((i < 2) ? 1'b1 : 1'b0);
            if (i <= LAT) chk("stuck_resume", 32'(o_stuck), (i < LAT) ? 32'd1 : 32'd0);
        end
        prev_h = 2; prev_l = 2; armed = 1'b1;
        repeat (2) period(2, 2, 4);

        // Disable coincident with a rise: no pulse, outputs hold
        I_en = 1'b0;
        cyc(1'b1); cyc(1'b1); cyc(1'b0);
        chk("dis_hold_period", 32'(o_period), 32'd4);
        chk("dis_stuck",       32'(o_stuck),  32'd0);
        I_en = 1'b1;
        cyc(1'b0);
        armed = 1'b0;
        repeat (3) period(2, 2, 4);

        // Reset mid-period: partial period discarded, outputs cleared
        period(2, 1, 4);
        I_rst = 1'b1;
        cyc(1'b0);
        I_rst = 1'b0;
        chk("mid_rst_period", 32'(o_period), 32'd0);
        chk("mid_rst_high",   32'(o_high),   32'd0);
        cyc(1'b0);
        armed = 1'b0;
        repeat (3) period(3, 3, 6);

        repeat (6) cyc(1'b0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
